// File: rtl/key_debounce_array.sv
// key_debounce_array
//   Multi-key push-button debouncer. A single shared prescaler produces a
//   one-cycle tick; every key channel has its own 2-FF synchroniser and a
//   tick-driven debounce FSM. Each channel reports a debounced level plus
//   one-cycle press / release / long-press / auto-repeat pulses.
//
// Ports (top):
//   clk          in   system clock, posedge
//   rstn         in   asynchronous active-low reset
//   key_in       in   [NUM_KEYS] raw asynchronous key pins
//   key_state    out  [NUM_KEYS] debounced level, 1 = pressed
//   key_press    out  [NUM_KEYS] 1-cycle pulse on accepted press
//   key_release  out  [NUM_KEYS] 1-cycle pulse on accepted release
//   key_long     out  [NUM_KEYS] 1-cycle pulse when hold reaches LONG_TICKS
//   key_repeat   out  [NUM_KEYS] 1-cycle pulse every REPEAT_TICKS while long
//
// Sub-module key_debounce_chan: one channel (synchroniser + FSM + counters).

module key_debounce_chan #(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 100,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_key,
  output logic o_state,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int RW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
  localparam logic REL_LVL = (ACTIVE_LOW != 0);
  localparam bit   REP_EN  = (REPEAT_TICKS > 0);

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_TICKS);
  localparam logic [RW-1:0] R_LAST = RW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

  localparam logic [2:0] S_RELEASED = 3'd0;
  localparam logic [2:0] S_PWAIT    = 3'd1;
  localparam logic [2:0] S_PRESSED  = 3'd2;
  localparam logic [2:0] S_LONG     = 3'd3;
  localparam logic [2:0] S_RWAIT    = 3'd4;

  logic [1:0]    r_sync;
  logic [2:0]    r_st;
  logic [DW-1:0] r_dcnt;
  logic [HW-1:0] r_hcnt;
  logic [RW-1:0] r_rcnt;
  logic          r_from_long;   // where RELEASE_WAIT returns to on a bounce
  logic          w_lvl;

  // Synchroniser idles at the released pin level so reset looks like "not pressed".
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= {2{REL_LVL}};
    else          r_sync <= {r_sync[0], i_key};
  end

  assign w_lvl = r_sync[1] ^ REL_LVL;

  // Level checks come first in every state: a level change on a tick cycle
  // clears/redirects and the tick is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st        <= S_RELEASED;
      r_dcnt      <= '0;
      r_hcnt      <= '0;
      r_rcnt      <= '0;
      r_from_long <= 1'b0;
      o_state     <= 1'b0;
      o_press     <= 1'b0;
      o_release   <= 1'b0;
      o_long      <= 1'b0;
      o_repeat    <= 1'b0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;
      case (r_st)
        S_RELEASED: begin
          if (w_lvl) begin
            r_st   <= S_PWAIT;
            r_dcnt <= '0;
          end
        end
        S_PWAIT: begin
          if (!w_lvl) begin
            r_st <= S_RELEASED;
          end else if (i_tick) begin
            if (r_dcnt == D_LAST) begin
              r_st    <= S_PRESSED;
              o_state <= 1'b1;
              o_press <= 1'b1;
              r_hcnt  <= '0;
            end else begin
              r_dcnt <= r_dcnt + 1'b1;
            end
          end
        end
        S_PRESSED: begin
          if (!w_lvl) begin
            r_st        <= S_RWAIT;
            r_dcnt      <= '0;
            r_from_long <= 1'b0;
          end else if (i_tick && (r_hcnt != H_MAX)) begin
            r_hcnt <= r_hcnt + 1'b1;   // saturates at LONG_TICKS
            if (r_hcnt == H_LAST) begin
              r_st   <= S_LONG;
              o_long <= 1'b1;
              r_rcnt <= '0;
            end
          end
        end
        S_LONG: begin
          if (!w_lvl) begin
            r_st        <= S_RWAIT;
            r_dcnt      <= '0;
            r_from_long <= 1'b1;
          end else if (REP_EN && i_tick) begin
            if (r_rcnt == R_LAST) begin
              o_repeat <= 1'b1;
              r_rcnt   <= '0;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
        end
        S_RWAIT: begin
          // hcnt/rcnt are untouched here, so a rejected release resumes them.
          if (w_lvl) begin
            r_st <= r_from_long ? S_LONG : S_PRESSED;
          end else if (i_tick) begin
            if (r_dcnt == D_LAST) begin
              r_st      <= S_RELEASED;
              o_state   <= 1'b0;
              o_release <= 1'b1;
            end else begin
              r_dcnt <= r_dcnt + 1'b1;
            end
          end
        end
        default: r_st <= S_RELEASED;
      endcase
    end
  end

endmodule

module key_debounce_array #(
  parameter int NUM_KEYS       = 4,
  parameter int TICK_CYCLES    = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 100,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0] r_pcnt;
  logic          r_tick;

  // Free-running prescaler; tick is high for the cycle in which it sits at 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_pcnt == P_LAST);
      if (r_pcnt == P_LAST) r_pcnt <= '0;
      else                  r_pcnt <= r_pcnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .LONG_TICKS     (LONG_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .i_clk     (clk),
      .i_rst_n   (rstn),
      .i_tick    (r_tick),
      .i_key     (key_in[g]),
      .o_state   (key_state[g]),
      .o_press   (key_press[g]),
      .o_release (key_release[g]),
      .o_long    (key_long[g]),
      .o_repeat  (key_repeat[g])
    );
  end

endmodule

// File: doc/key_debounce_array.md
Name: key_debounce_array

Overview:
Parametrised multi-key debouncer for board push-buttons; the successor to the single-key 20 ms debouncer.
- One shared prescaler produces a tick. Each channel runs its own 2-FF synchroniser and a tick-based debounce FSM.
- Per key it outputs a debounced level, plus one-cycle press, release, long-press and auto-repeat pulses.
- Sits between raw key pins and the AE350 GPIO/interrupt logic.

Parameters:
NUM_KEYS, 4, number of independent key channels (1..32)
TICK_CYCLES, 50000, clk cycles per tick (1 ms at 50 MHz); must be >= 2
DEBOUNCE_TICKS, 20, stable ticks required to accept a press or release (>= 1)
LONG_TICKS, 1000, ticks held (debounced) before the long-press pulse; must be > DEBOUNCE_TICKS
REPEAT_TICKS, 100, auto-repeat period after long press; 0 disables repeat
ACTIVE_LOW, 1, 1: raw input low = pressed; 0: raw input high = pressed

Ports:
clk  in  1  system clock; all logic is on posedge
rstn  in  1  asynchronous active-low reset
key_in  in  NUM_KEYS  raw asynchronous key pins
key_state  out  NUM_KEYS  debounced level, 1 = pressed
key_press  out  NUM_KEYS  1-cycle pulse when a press is accepted
key_release  out  NUM_KEYS  1-cycle pulse when a release is accepted
key_long  out  NUM_KEYS  1-cycle pulse when hold time reaches LONG_TICKS
key_repeat  out  NUM_KEYS  1-cycle pulse every REPEAT_TICKS while in the long state

Behaviour:
- Interface: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values:
  - all outputs 0.
  - synchroniser flops = released level (1 if ACTIVE_LOW, else 0).
  - FSMs = RELEASED.
  - all counters 0.
- Prescaler:
  - a free-running counter 0..TICK_CYCLES-1.
  - tick is a 1-cycle strobe when it wraps to 0.
  - it is shared by all channels and is never reset except by rstn.
- Synchroniser: 2 flops per key. lvl = synchronised value XOR ACTIVE_LOW, so lvl = 1 means pressed.
- Per-channel state: FSM; debounce counter dcnt (width clog2(DEBOUNCE_TICKS+1)); hold counter hcnt (width clog2(LONG_TICKS+1)); repeat counter rcnt.
- FSM states and transitions:
  - RELEASED: lvl=1 -> PRESS_WAIT, dcnt=0.
  - PRESS_WAIT:
    - lvl=0 -> RELEASED (bounce rejected, no pulse).
    - Otherwise dcnt increments on each tick. When dcnt reaches DEBOUNCE_TICKS: go to PRESSED, key_state=1, pulse key_press, hcnt=0.
  - PRESSED:
    - hcnt increments on tick; it saturates and never wraps.
    - When hcnt reaches LONG_TICKS: go to LONG, pulse key_long, rcnt=0.
    - lvl=0 -> RELEASE_WAIT, dcnt=0, remember origin = PRESSED.
  - LONG:
    - If REPEAT_TICKS>0: rcnt increments on tick. At REPEAT_TICKS, pulse key_repeat and set rcnt=0.
    - lvl=0 -> RELEASE_WAIT, dcnt=0, origin = LONG.
  - RELEASE_WAIT:
    - lvl=1 -> return to origin. hcnt and rcnt are frozen while in RELEASE_WAIT and resume from their values on return.
    - dcnt increments on tick. At DEBOUNCE_TICKS: go to RELEASED, key_state=0, pulse key_release.
- Latency:
  - acceptance occurs (DEBOUNCE_TICKS-1)*TICK_CYCLES+1 to DEBOUNCE_TICKS*TICK_CYCLES cycles after lvl settles (first tick may be partial).
  - add 2 cycles of synchroniser delay, plus 1 cycle for the registered outputs.
- Pulse timing: all pulses are registered and exactly 1 clk wide. key_state changes in the same cycle as key_press or key_release.
- Simultaneous events:
  - If the lvl change and the tick coincide, the lvl change wins: the counter clears and the tick is not counted.
  - key_long and key_repeat never fire in the same cycle.
  - Channels are fully independent; any combination of channel pulses may coincide.
- Long press ends in release: when a long press is released, key_release fires but no extra key_press fires.
- Reset mid-operation: asserting rstn at any point immediately forces all outputs to 0 and all FSMs to RELEASED. A key still held after rstn deasserts is debounced afresh and produces key_press.

Test Plan:
Common bench parameters: NUM_KEYS=4, TICK_CYCLES=10, DEBOUNCE_TICKS=4, LONG_TICKS=20, REPEAT_TICKS=5, ACTIVE_LOW=1.
- Clean press: key_in[0] goes 1->0 and holds -> key_state[0] rises and key_press[0] pulses once, 33..43 cycles after the edge; other channels stay 0.
- Bounce: key_in[1] toggles every 7 cycles for 200 cycles, then settles high -> no pulses and key_state[1]=0 throughout.
- Long/repeat: hold key_in[2] low for 400 cycles -> key_press, then key_long about 200 cycles later, then key_repeat every 50 cycles. Release -> a single key_release, no extra press.
- Release glitch: key held (PRESSED), then a 25-cycle high glitch -> no release pulse, key_state stays 1, and hold time resumes (key_long is delayed only by the glitch duration).
- Simultaneous: keys 0 and 3 pressed in the same cycle -> key_press pulses in the same cycle on bits 0 and 3.
- Reset: assert rstn for 3 cycles mid-LONG -> all outputs 0 immediately. After release of rstn with the key still held -> a fresh key_press after the debounce time.
